synch_fifo_ctrl: RTL and testbench

Single-clock FIFO controller that owns the write and read ports of the team's 16x8 dual-port sram. It turns push/pop requests into sram write/read strobes and pointers, and tracks occupancy. It flags full, empty, almost-full, almost-empty, overflow and underflow. It retimes the sram's registered read data into a valid-qualified output. Together with sram it forms synch_fifo.

---
 rtl/synch_fifo_ctrl_if.sv | 44 ++++
 rtl/synch_fifo_ctrl.sv | 84 ++++++++
 tb/tb_synch_fifo_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/synch_fifo_ctrl_if.sv
// Push/pop, status and sram port bundle shared by synch_fifo_ctrl and its users.
// master: FIFO user, slave: controller, sram: the dual-port array behind it.
interface synch_fifo_ctrl_if #(
   parameter int unsigned PTR   = 4,
   parameter int unsigned WIDTH = 8
);
   logic             wr_req;
   logic [WIDTH-1:0] wr_data;
   logic             rd_req;
   logic [WIDTH-1:0] rd_data;
   logic             rd_valid;
   logic             clr_err;
   logic             full;
   logic             empty;
   logic             almost_full;
   logic             almost_empty;
   logic [PTR:0]     count;
   logic             overflow;
   logic             underflow;
   logic             sram_wren;
   logic [PTR-1:0]   sram_wrptr;
   logic [WIDTH-1:0] sram_wrdata;
   logic             sram_rden;
   logic [PTR-1:0]   sram_rdptr;
   logic [WIDTH-1:0] sram_rddata;

   modport master (
      output wr_req, wr_data, rd_req, clr_err,
      input  rd_data, rd_valid, full, empty, almost_full, almost_empty, count,
      input  overflow, underflow
   );

   modport slave (
      input  wr_req, wr_data, rd_req, clr_err, sram_rddata,
      output rd_data, rd_valid, full, empty, almost_full, almost_empty, count,
      output overflow, underflow,
      output sram_wren, sram_wrptr, sram_wrdata, sram_rden, sram_rdptr
   );

   modport sram (
      input  sram_wren, sram_wrptr, sram_wrdata, sram_rden, sram_rdptr,
      output sram_rddata
   );
endinterface

// File: rtl/synch_fifo_ctrl.sv
// Single-clock FIFO controller driving a 16x8 dual-port sram with registered read data.
// Tracks occupancy, raises status flags and sticky overflow/underflow errors.
module synch_fifo_ctrl #(
   parameter int unsigned PTR      = 4,
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned DEPTH    = 16,
   parameter int unsigned AF_LEVEL = 12,
   parameter int unsigned AE_LEVEL = 2
) (
   input logic              clk,
   input logic              rst_n,
   synch_fifo_ctrl_if.slave bus
);
   localparam logic [PTR:0]   DEPTH_C = (PTR+1)'(DEPTH);
   localparam logic [PTR:0]   AF_C    = (PTR+1)'(AF_LEVEL);
   localparam logic [PTR:0]   AE_C    = (PTR+1)'(AE_LEVEL);
   localparam logic [PTR:0]   CNT_ONE = (PTR+1)'(1);
   localparam logic [PTR-1:0] PTR_ONE = PTR'(1);

   logic [PTR-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR:0]   count_q, count_d;
   logic           overflow_q, overflow_d;
   logic           underflow_q, underflow_d;
   logic           rd_valid_q, rd_valid_d;
   logic           full, empty, wr_acc, rd_acc;

   always_comb begin
      full   = (count_q == DEPTH_C);
      empty  = (count_q == '0);
      wr_acc = bus.wr_req & ~full;
      rd_acc = bus.rd_req & ~empty;

      wr_ptr_d = wr_acc ? wr_ptr_q + PTR_ONE : wr_ptr_q;
      rd_ptr_d = rd_acc ? rd_ptr_q + PTR_ONE : rd_ptr_q;

      count_d = count_q;
      unique case ({wr_acc, rd_acc})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase

      // A new error event in the same cycle as clr_err keeps the flag set.
      overflow_d  = (bus.wr_req & full) | (overflow_q & ~bus.clr_err);
      underflow_d = (bus.rd_req & empty) | (underflow_q & ~bus.clr_err);
      rd_valid_d  = rd_acc;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         rd_valid_q  <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
         rd_valid_q  <= rd_valid_d;
      end
   end

   always_comb begin
      bus.full         = full;
      bus.empty        = empty;
      bus.almost_full  = (count_q >= AF_C);
      bus.almost_empty = (count_q <= AE_C);
      bus.count        = count_q;
      bus.overflow     = overflow_q;
      bus.underflow    = underflow_q;
      bus.rd_valid     = rd_valid_q;
      bus.rd_data      = bus.sram_rddata;
      bus.sram_wren    = wr_acc;
      bus.sram_wrptr   = wr_ptr_q;
      bus.sram_wrdata  = bus.wr_data;
      bus.sram_rden    = rd_acc;
      bus.sram_rdptr   = rd_ptr_q;
   end
endmodule

// File: tb/tb_synch_fifo_ctrl.sv
// Bench for synch_fifo_ctrl: queue-based FIFO model checked every cycle, directed
// scenarios with literal expectations, then randomized push/pop/clear traffic.
module tb_synch_fifo_ctrl;
   localparam int DEPTH = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   tests = 0;
   int   fails = 0;

   synch_fifo_ctrl_if #(.PTR(4), .WIDTH(8)) bus ();

   synch_fifo_ctrl #(
      .PTR(4), .WIDTH(8), .DEPTH(16), .AF_LEVEL(12), .AE_LEVEL(2)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   // Registered-read sram stand-in.
   logic [7:0] mem [16];
   always_ff @(posedge clk) begin
      if (bus.sram_wren) mem[bus.sram_wrptr] <= bus.sram_wrdata;
      if (bus.sram_rden) bus.sram_rddata <= mem[bus.sram_rdptr];
   end

   // Reference model: occupancy is the queue length, data order is the queue order.
   logic [7:0] mq[$];
   int         wr_n, rd_n;
   bit         m_ov, m_uf, m_vld;
   logic [7:0] m_data;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq.delete();
         wr_n = 0; rd_n = 0; m_ov = 0; m_uf = 0; m_vld = 0; m_data = '0;
      end else begin : model_step
         bit f, e;
         f = (mq.size() == DEPTH);
         e = (mq.size() == 0);
         m_ov  = (bus.wr_req && f) || (m_ov && !bus.clr_err);
         m_uf  = (bus.rd_req && e) || (m_uf && !bus.clr_err);
         m_vld = bus.rd_req && !e;
         if (m_vld) begin
            m_data = mq.pop_front();
            rd_n++;
         end
         if (bus.wr_req && !f) begin
            mq.push_back(bus.wr_data);
            wr_n++;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin : compare
      int n;
      n = mq.size();
      chk("count", 32'(bus.count), 32'(n));
      chk("full", 32'(bus.full), 32'(n == DEPTH));
      chk("empty", 32'(bus.empty), 32'(n == 0));
      chk("almost_full", 32'(bus.almost_full), 32'(n >= 12));
      chk("almost_empty", 32'(bus.almost_empty), 32'(n <= 2));
      chk("overflow", 32'(bus.overflow), 32'(m_ov));
      chk("underflow", 32'(bus.underflow), 32'(m_uf));
      chk("rd_valid", 32'(bus.rd_valid), 32'(m_vld));
      if (m_vld) chk("rd_data", 32'(bus.rd_data), 32'(m_data));
      chk("sram_wren", 32'(bus.sram_wren), 32'(bus.wr_req && n != DEPTH));
      chk("sram_rden", 32'(bus.sram_rden), 32'(bus.rd_req && n != 0));
      chk("sram_wrptr", 32'(bus.sram_wrptr), 32'(wr_n % DEPTH));
      chk("sram_rdptr", 32'(bus.sram_rdptr), 32'(rd_n % DEPTH));
      if (bus.wr_req) chk("sram_wrdata", 32'(bus.sram_wrdata), 32'(bus.wr_data));
   end

   task automatic drive(input bit w, input logic [7:0] d, input bit r, input bit c);
      bus.wr_req  = w;
      bus.wr_data = d;
      bus.rd_req  = r;
      bus.clr_err = c;
   endtask

   task automatic cyc(input bit w, input logic [7:0] d, input bit r, input bit c);
      drive(w, d, r, c);
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      drive(0, 8'h00, 0, 0);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #2;
   endtask

   initial begin
      drive(0, 8'h00, 0, 0);
      do_reset();
      chk("rst_empty", 32'(bus.empty), 1);
      chk("rst_full", 32'(bus.full), 0);
      chk("rst_count", 32'(bus.count), 0);
      chk("rst_ae", 32'(bus.almost_empty), 1);
      chk("rst_valid", 32'(bus.rd_valid), 0);
      chk("rst_ov", 32'(bus.overflow), 0);

      // Fill with 0x00..0x0F, then one rejected push.
      for (int i = 0; i < 16; i++) begin
         cyc(1, 8'(i), 0, 0);
         if (i == 10) chk("af_at11", 32'(bus.almost_full), 0);
         if (i == 11) chk("af_at12", 32'(bus.almost_full), 1);
      end
      chk("full_16", 32'(bus.full), 1);
      drive(1, 8'hAA, 0, 0);
      #1 chk("xpush_wren", 32'(bus.sram_wren), 0);
      @(posedge clk); #2;
      chk("xpush_ov", 32'(bus.overflow), 1);
      chk("xpush_count", 32'(bus.count), 16);
      cyc(0, 8'h00, 0, 1);
      chk("clr_ov", 32'(bus.overflow), 0);

      // Drain back-to-back; each datum appears one cycle after its accepting edge.
      for (int i = 0; i < 16; i++) begin
         cyc(0, 8'h00, 1, 0);
         chk("pop_valid", 32'(bus.rd_valid), 1);
         chk("pop_data", 32'(bus.rd_data), 32'(i));
      end
      chk("drain_empty", 32'(bus.empty), 1);
      drive(0, 8'h00, 1, 0);
      #1 chk("xpop_rden", 32'(bus.sram_rden), 0);
      @(posedge clk); #2;
      chk("xpop_uf", 32'(bus.underflow), 1);
      chk("xpop_valid", 32'(bus.rd_valid), 0);
      cyc(0, 8'h00, 0, 1);

      // Push 3 / pop 3 across the pointer wrap.
      for (int r = 0; r < 10; r++) begin
         for (int k = 0; k < 3; k++) cyc(1, 8'(8'h40 + r * 3 + k), 0, 0);
         for (int k = 0; k < 3; k++) begin
            cyc(0, 8'h00, 1, 0);
            chk("wrap_data", 32'(bus.rd_data), 32'(8'h40 + r * 3 + k));
         end
         chk("wrap_count", 32'(bus.count), 0);
      end
      chk("wrap_wrptr", 32'(bus.sram_wrptr), 14);
      chk("wrap_rdptr", 32'(bus.sram_rdptr), 14);

      // Simultaneous push+pop at full, empty and mid occupancy.
      for (int i = 0; i < 16; i++) cyc(1, 8'(8'h80 + i), 0, 0);
      cyc(1, 8'hEE, 1, 0);
      chk("both_full_count", 32'(bus.count), 15);
      chk("both_full_ov", 32'(bus.overflow), 1);
      cyc(0, 8'h00, 0, 1);
      for (int i = 0; i < 15; i++) cyc(0, 8'h00, 1, 0);
      cyc(1, 8'h11, 1, 0);
      chk("both_empty_count", 32'(bus.count), 1);
      chk("both_empty_uf", 32'(bus.underflow), 1);
      chk("both_empty_valid", 32'(bus.rd_valid), 0);
      cyc(0, 8'h00, 0, 1);
      for (int i = 0; i < 4; i++) cyc(1, 8'(8'h20 + i), 0, 0);
      cyc(1, 8'h33, 1, 0);
      chk("both_mid_count", 32'(bus.count), 5);
      chk("both_mid_valid", 32'(bus.rd_valid), 1);
      chk("both_mid_data", 32'(bus.rd_data), 32'h11);
      cyc(0, 8'h00, 0, 0);
      chk("both_mid_once", 32'(bus.rd_valid), 0);

      // Reset while a pop is in flight at count 7.
      for (int i = 0; i < 3; i++) cyc(1, 8'(8'h50 + i), 0, 0);
      cyc(0, 8'h00, 1, 0);
      chk("pre_rst_count", 32'(bus.count), 7);
      rst_n = 1'b0;
      #1;
      chk("arst_count", 32'(bus.count), 0);
      chk("arst_empty", 32'(bus.empty), 1);
      chk("arst_valid", 32'(bus.rd_valid), 0);
      do_reset();
      chk("post_rst_valid", 32'(bus.rd_valid), 0);

      // New overflow in the same cycle as clr_err keeps the flag.
      for (int i = 0; i < 16; i++) cyc(1, 8'(i * 7), 0, 0);
      cyc(1, 8'hAB, 0, 1);
      chk("set_wins_ov", 32'(bus.overflow), 1);
      cyc(0, 8'h00, 0, 1);
      chk("clr_after", 32'(bus.overflow), 0);

      // Randomized traffic with drifting push/pop bias to visit full and empty.
      for (int i = 0; i < 3000; i++) begin
         int ph;
         bit w, r;
         ph = (i / 200) % 3;
         w  = (ph == 0) ? ($urandom_range(3) != 0) :
              (ph == 1) ? ($urandom_range(3) == 0) : ($urandom_range(1) == 1);
         r  = (ph == 0) ? ($urandom_range(3) == 0) :
              (ph == 1) ? ($urandom_range(3) != 0) : ($urandom_range(1) == 1);
         cyc(w, 8'($urandom), r, ($urandom_range(15) == 0));
      end

      cyc(0, 8'h00, 0, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
